qspi_cmd_master: RTL and testbench
==================================

Name: qspi_cmd_master

Overview:
- Single-lane (SPI mode 0) command master for the QSPI flash device.
- Issues an 8-bit opcode, an optional 24-bit address and optional dummy clocks, then reads N bytes from IO1.
- Sits between the system-side control logic and the flash pins: it is the initiator end of the link the flash responder serves. Typical command is the 0x9F JEDEC ID read.
- The pad tristates live outside this block; it exposes separate out/oe/in signals.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range ≥1.
- CNT_W, 8, width of the rd_len byte counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- opcode  in  8  command byte.
- addr  in  24  address, sent MSB first.
- addr_en  in  1  1 = send the address phase.
- rd_len  in  CNT_W  number of bytes to read; 0 = no read phase.
- dummy_cycles  in  4  dummy SCLKs; honoured only with the optional feature.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of the transaction.
- rd_data  out  8  last received byte.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- qspi_sclk  out  1  serial clock; idles low.
- qspi_cs_n  out  1  chip select, active low.
- qspi_io0_o  out  1  MOSI data.
- qspi_io0_oe  out  1  IO0 output enable.
- qspi_io1_i  in  1  MISO data.
- qspi_io2_o  out  1  WP#; constant 1.
- qspi_io3_o  out  1  HOLD#; constant 1.
- qspi_io23_oe  out  1  IO2/IO3 output enable; constant 1 except during reset.

Behaviour:
- Reset values:
  - qspi_cs_n=1, qspi_sclk=0, qspi_io0_o=0, qspi_io0_oe=0, qspi_io23_oe=0.
  - busy=0, done=0, rd_valid=0, rd_data=8'h00.
  - State = IDLE.
- Reset mid-transaction: CS deasserts immediately (asynchronous). No done pulse, no rd_valid pulse.
- Inputs are captured on the cycle start is accepted. Later changes to the inputs do not affect the running transaction.
- start while busy is ignored and the request is lost.
- Mode-0 SCLK timing:
  - Each SCLK phase lasts CLK_DIV clk cycles, tracked by a half-period counter.
  - IO0 changes only while SCLK is low; the first bit is valid before the first rising edge.
  - IO1 is sampled in the clk cycle in which SCLK rises.
- State machine:
  - IDLE: CS high. On start → CS_SETUP, with busy=1.
  - CS_SETUP: CS low, SCLK low, io0_oe=1, io0_o=opcode[7]. Lasts one half-period, then → CMD.
  - CMD: 8 SCLK periods, opcode sent MSB first. Next: ADDR if addr_en; else DUMMY if dummy count >0; else READ if rd_len≠0; else CS_HOLD.
  - ADDR: 24 periods, addr[23:0] sent MSB first. Next follows the same selection rule, starting from DUMMY.
  - DUMMY: N periods with io0_oe=0. Next: READ or CS_HOLD.
  - READ: io0_oe=0. Bits shift in MSB first. On the 8th rising edge of each byte: rd_data is updated and rd_valid pulses on the same cycle. The byte counter decrements; at 0 → CS_HOLD.
  - CS_HOLD: SCLK low for one half-period, then CS high and io0_oe=0 → CS_GAP.
  - CS_GAP: CS high for one half-period, then done=1 for one cycle, busy=0, → IDLE.
- Total rising edges per transaction = 8 + 24·addr_en + N + 8·rd_len. No extra SCLK edges occur while CS is high.
- rd_len=0 gives a command-only transaction (e.g. 0x06 Write Enable).
- rd_data holds its value between transactions.

Optional Feature:
- Macro: QSPI_CMD_MASTER_DUMMY_EN.
- Defined: the DUMMY phase uses N = dummy_cycles, range 0–15. This supports 0x0B Fast Read with 8 dummy cycles.
- Undefined: dummy_cycles is ignored, N=0, and the DUMMY state plus its counter are not synthesised.

Test Plan:
- JEDEC ID: opcode=9F, addr_en=0, rd_len=3, slave model returns EF 40 18 → io0 carries 10011111; 32 rising edges; rd_valid pulses with EF, 40, 18 in order; single done pulse; busy low afterwards.
- Write Enable: opcode=06, addr_en=0, rd_len=0 → exactly 8 edges, pattern 00000110; no rd_valid; CS low for 8 periods + 2 half-periods.
- Read: opcode=03, addr=0x123456, addr_en=1, rd_len=2, slave returns A5 5A → 48 edges; address bits match; io0_oe=0 during reads; rd_data A5 then 5A.
- Protocol robustness, three sub-cases:
  - start pulsed mid-transaction → ignored.
  - rst asserted during ADDR → CS high and SCLK low with no clk edge needed; no done; a fresh 9F after reset works.
  - CLK_DIV=1 and CLK_DIV=4 → SCLK period is 2 and 8 clk cycles respectively.
- With QSPI_CMD_MASTER_DUMMY_EN: opcode=0B, addr=0, dummy_cycles=8, rd_len=1 → 8+24+8+8=48 edges; rd_data equals the slave byte. Without the macro, the same stimulus gives 40 edges.

Source files
------------

// File: rtl/qspi_cmd_master.sv
// qspi_cmd_master: single-lane SPI mode-0 command master for a QSPI flash.
// Sends an 8-bit opcode, an optional 24-bit address and optional dummy
// clocks on IO0, then shifts rd_len bytes in from IO1 (MSB first).
// Optional feature macro: QSPI_CMD_MASTER_DUMMY_EN enables the DUMMY phase
// (dummy_cycles SCLKs); without it dummy_cycles is ignored.
module qspi_cmd_master #(
    parameter int CLK_DIV = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       opcode,
    input  logic [23:0]      addr,
    input  logic             addr_en,
    input  logic [CNT_W-1:0] rd_len,
    input  logic [3:0]       dummy_cycles,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             qspi_sclk,
    output logic             qspi_cs_n,
    output logic             qspi_io0_o,
    output logic             qspi_io0_oe,
    input  logic             qspi_io1_i,
    output logic             qspi_io2_o,
    output logic             qspi_io3_o,
    output logic             qspi_io23_oe
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
`ifdef QSPI_CMD_MASTER_DUMMY_EN
        ST_DUMMY,
`endif
        ST_READ,
        ST_CS_HOLD,
        ST_CS_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_after_addr;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_sclk;
    logic [4:0]        r_bit_cnt;
    logic [31:0]       r_tx;
    logic [6:0]        r_rx;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic              r_addr_en;
    logic              r_io0_oe;
    logic              r_io23_oe;
    logic              r_done;
    logic              r_rd_valid;
    logic [7:0]        r_rd_data;
    logic              w_phase_end;
    logic              w_shifting;
    logic              w_rise;
    logic              w_fall;
    logic              w_last_bit;
    logic              w_start_ok;
`ifdef QSPI_CMD_MASTER_DUMMY_EN
    logic [3:0]        r_dummy;
`else
    logic              w_unused_dummy;
    assign w_unused_dummy = ^dummy_cycles;
`endif

    assign w_phase_end = (r_div_cnt == DIV_LAST);
    assign w_start_ok  = (r_state == ST_IDLE) && start;
    assign w_rise      = w_shifting && w_phase_end && !r_sclk;
    assign w_fall      = w_shifting && w_phase_end && r_sclk;

    // Which states toggle SCLK, and whether the current period ends the phase
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_shifting = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_READ);
        w_last_bit = 1'b0;
        case (r_state)
            ST_CMD:   w_last_bit = (r_bit_cnt == 5'd7);
            ST_ADDR:  w_last_bit = (r_bit_cnt == 5'd23);
            ST_READ:  w_last_bit = (r_bit_cnt == 5'd7);
`ifdef QSPI_CMD_MASTER_DUMMY_EN
            ST_DUMMY: begin
                w_shifting = 1'b1;
                w_last_bit = (r_bit_cnt == {1'b0, r_dummy - 4'd1});
            end
`endif
            default:  w_last_bit = 1'b0;
        endcase
    end

    // Phase that follows the address (or the opcode when no address is sent)
    always_comb begin
        w_after_addr = (r_byte_cnt != '0) ? ST_READ : ST_CS_HOLD;
`ifdef QSPI_CMD_MASTER_DUMMY_EN
        if (r_dummy != 4'd0) w_after_addr = ST_DUMMY;
`endif
    end

    // Next-state logic; shift phases advance only on the falling SCLK edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_state_nxt = ST_CS_SETUP;
            ST_CS_SETUP: if (w_phase_end) w_state_nxt = ST_CMD;
            ST_CMD:      if (w_fall && w_last_bit) w_state_nxt = r_addr_en ? ST_ADDR : w_after_addr;
            ST_ADDR:     if (w_fall && w_last_bit) w_state_nxt = w_after_addr;
`ifdef QSPI_CMD_MASTER_DUMMY_EN
            ST_DUMMY:    if (w_fall && w_last_bit) w_state_nxt = (r_byte_cnt != '0) ? ST_READ : ST_CS_HOLD;
`endif
            ST_READ:     if (w_fall && w_last_bit && (r_byte_cnt == '0)) w_state_nxt = ST_CS_HOLD;
            ST_CS_HOLD:  if (w_phase_end) w_state_nxt = ST_CS_GAP;
            ST_CS_GAP:   if (w_phase_end) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Datapath: half-period timer, SCLK, shift registers, byte counter, pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_bit_cnt  <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_byte_cnt <= '0;
            r_addr_en  <= 1'b0;
            r_io0_oe   <= 1'b0;
            r_io23_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
`ifdef QSPI_CMD_MASTER_DUMMY_EN
            r_dummy    <= '0;
`endif
        end else begin
            r_io23_oe  <= 1'b1;
            r_done     <= (r_state == ST_CS_GAP) && w_phase_end;
            r_rd_valid <= 1'b0;

            if (r_state == ST_IDLE) r_div_cnt <= '0;
            else                    r_div_cnt <= w_phase_end ? '0 : r_div_cnt + 1'b1;

            if (w_rise)      r_sclk <= 1'b1;
            else if (w_fall) r_sclk <= 1'b0;

            // Inputs are frozen here; later input changes cannot disturb the transfer
            if (w_start_ok) begin
                r_tx       <= {opcode, addr};
                r_addr_en  <= addr_en;
                r_byte_cnt <= rd_len;
                r_bit_cnt  <= '0;
`ifdef QSPI_CMD_MASTER_DUMMY_EN
                r_dummy    <= dummy_cycles;
`endif
            end

            // IO0 only moves on the falling edge so it is stable across each rise
            if (w_fall) begin
                r_tx      <= {r_tx[30:0], 1'b0};
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            end

            if (w_rise && (r_state == ST_READ)) begin
                r_rx <= {r_rx[5:0], qspi_io1_i};
                if (r_bit_cnt == 5'd7) begin
                    r_rd_data  <= {r_rx, qspi_io1_i};
                    r_rd_valid <= 1'b1;
                    r_byte_cnt <= r_byte_cnt - 1'b1;
                end
            end

            // Drive IO0 from CS_SETUP through the last command/address bit
            if (w_start_ok)
                r_io0_oe <= 1'b1;
            else if (!(w_state_nxt inside {ST_CS_SETUP, ST_CMD, ST_ADDR, ST_CS_HOLD}))
                r_io0_oe <= 1'b0;
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign qspi_sclk    = r_sclk;
    assign qspi_cs_n    = (r_state == ST_IDLE) || (r_state == ST_CS_GAP);
    assign qspi_io0_o   = r_tx[31] & r_io0_oe;
    assign qspi_io0_oe  = r_io0_oe;
    assign qspi_io2_o   = 1'b1;
    assign qspi_io3_o   = 1'b1;
    assign qspi_io23_oe = r_io23_oe;

endmodule

// File: tb/tb_qspi_cmd_master.sv
// tb_qspi_cmd_master: directed + randomized bench for qspi_cmd_master.
// A negedge monitor records the serial link and plays a flash responder;
// expectations come from the transaction rules (edge counts, bit streams).
module tb_qspi_cmd_master;

    localparam int CLK_DIV = 2;
`ifdef QSPI_CMD_MASTER_DUMMY_EN
    localparam bit DUMMY_EN = 1'b1;
`else
    localparam bit DUMMY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [7:0]  opcode;
    logic [23:0] addr;
    logic        addr_en;
    logic [7:0]  rd_len;
    logic [3:0]  dummy_cycles;
    logic        busy, done, rd_valid;
    logic [7:0]  rd_data;
    logic        qspi_sclk, qspi_cs_n, qspi_io0_o, qspi_io0_oe;
    logic        qspi_io2_o, qspi_io3_o, qspi_io23_oe;
    logic        io1 = 1'b0;

    qspi_cmd_master #(.CLK_DIV(CLK_DIV), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .addr(addr),
        .addr_en(addr_en), .rd_len(rd_len), .dummy_cycles(dummy_cycles),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .qspi_sclk(qspi_sclk), .qspi_cs_n(qspi_cs_n), .qspi_io0_o(qspi_io0_o),
        .qspi_io0_oe(qspi_io0_oe), .qspi_io1_i(io1), .qspi_io2_o(qspi_io2_o),
        .qspi_io3_o(qspi_io3_o), .qspi_io23_oe(qspi_io23_oe)
    );

    // Two extra instances only for SCLK-period checks at other dividers
    logic       start_d1, start_d4;
    logic       x_io1 = 1'b0;
    logic [1:0] x_sclk, x_cs_n;
    logic [1:0] unused_busy, unused_done, unused_rd_valid, unused_io0, unused_oe;
    logic [1:0] unused_io2, unused_io3, unused_io23;
    logic [7:0] unused_rd_data [2];

    qspi_cmd_master #(.CLK_DIV(1), .CNT_W(8)) u_div1 (
        .clk(clk), .rst(rst), .start(start_d1), .opcode(opcode), .addr(addr),
        .addr_en(addr_en), .rd_len(rd_len), .dummy_cycles(dummy_cycles),
        .busy(unused_busy[0]), .done(unused_done[0]), .rd_data(unused_rd_data[0]),
        .rd_valid(unused_rd_valid[0]), .qspi_sclk(x_sclk[0]), .qspi_cs_n(x_cs_n[0]),
        .qspi_io0_o(unused_io0[0]), .qspi_io0_oe(unused_oe[0]), .qspi_io1_i(x_io1),
        .qspi_io2_o(unused_io2[0]), .qspi_io3_o(unused_io3[0]), .qspi_io23_oe(unused_io23[0])
    );

    qspi_cmd_master #(.CLK_DIV(4), .CNT_W(8)) u_div4 (
        .clk(clk), .rst(rst), .start(start_d4), .opcode(opcode), .addr(addr),
        .addr_en(addr_en), .rd_len(rd_len), .dummy_cycles(dummy_cycles),
        .busy(unused_busy[1]), .done(unused_done[1]), .rd_data(unused_rd_data[1]),
        .rd_valid(unused_rd_valid[1]), .qspi_sclk(x_sclk[1]), .qspi_cs_n(x_cs_n[1]),
        .qspi_io0_o(unused_io0[1]), .qspi_io0_oe(unused_oe[1]), .qspi_io1_i(x_io1),
        .qspi_io2_o(unused_io2[1]), .qspi_io3_o(unused_io3[1]), .qspi_io23_oe(unused_io23[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- link monitor + flash responder (main DUT) ----------------
    int         rise_cnt = 0, cs_low_cyc = 0, done_cnt = 0, hi_edge_cnt = 0, io0_viol = 0;
    logic       mosi_q[$];
    logic       oe_q[$];
    logic [7:0] rx_q[$];
    logic       prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_io0 = 1'b0;
    logic [7:0] slv_mem [4];
    int         slv_hdr = 0, slv_n = 0, slv_idx = 0;

    always @(negedge clk) begin
        if (!qspi_cs_n && prev_cs_n) begin
            rise_cnt = 0; cs_low_cyc = 0; done_cnt = 0;
            mosi_q.delete(); oe_q.delete(); rx_q.delete();
        end
        if (!qspi_cs_n) cs_low_cyc++;
        if (qspi_sclk && !prev_sclk) begin
            if (qspi_cs_n) hi_edge_cnt++;
            else begin
                mosi_q.push_back(qspi_io0_o);
                oe_q.push_back(qspi_io0_oe);
                rise_cnt++;
            end
        end
        if (!qspi_cs_n && qspi_sclk && (qspi_io0_o !== prev_io0)) io0_viol++;
        if (rd_valid) rx_q.push_back(rd_data);
        if (done) done_cnt++;
        // Responder presents the bit the next rising edge will sample
        slv_idx = rise_cnt - slv_hdr;
        if (!qspi_cs_n && slv_idx >= 0 && slv_idx < 8 * slv_n)
            io1 = slv_mem[slv_idx / 8][7 - (slv_idx % 8)];
        else
            io1 = 1'b0;
        prev_sclk = qspi_sclk;
        prev_cs_n = qspi_cs_n;
        prev_io0  = qspi_io0_o;
    end

    // ---------------- period monitor for the divider instances ----------------
    int         x_cyc = 0;
    int         x_rise [2];
    int         x_first [2];
    int         x_second [2];
    logic [1:0] x_prev_sclk = 2'b00, x_prev_cs_n = 2'b11;

    always @(negedge clk) begin
        x_cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!x_cs_n[k] && x_prev_cs_n[k]) x_rise[k] = 0;
            if (!x_cs_n[k] && x_sclk[k] && !x_prev_sclk[k]) begin
                if (x_rise[k] == 0) x_first[k] = x_cyc;
                if (x_rise[k] == 1) x_second[k] = x_cyc;
                x_rise[k]++;
            end
        end
        x_prev_sclk = x_sclk;
        x_prev_cs_n = x_cs_n;
    end

    // One complete transaction on the main DUT, checked against the rules
    task automatic run_txn(input string tag, input logic [7:0] op, input logic [23:0] ad,
                           input logic ae, input logic [7:0] len, input logic [3:0] dc,
                           input bit poke_start);
        int         n_dummy, n_rises, n_drive, budget, oe_bad;
        logic [7:0] obs8;
        logic [23:0] obs24;
        n_dummy = DUMMY_EN ? int'(dc) : 0;
        n_drive = 8 + 24 * int'(ae);
        n_rises = n_drive + n_dummy + 8 * int'(len);
        slv_hdr = n_drive + n_dummy;
        slv_n   = int'(len);
        @(negedge clk);
        opcode = op; addr = ad; addr_en = ae; rd_len = len; dummy_cycles = dc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        opcode = 8'($urandom); addr = 24'($urandom); addr_en = 1'($urandom);
        rd_len = 8'($urandom); dummy_cycles = 4'($urandom);
        check({tag, "_busy"}, 32'(busy), 1);
        budget = 0;
        while (!done && budget < 4000) begin
            @(negedge clk);
            budget++;
            start = poke_start && (budget == 20);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 1);
        repeat (6) @(negedge clk);
        check({tag, "_rises"}, 32'(rise_cnt), 32'(n_rises));
        obs8 = '0;
        for (int i = 0; i < 8; i++) obs8 = {obs8[6:0], (i < mosi_q.size()) ? mosi_q[i] : 1'bx};
        check({tag, "_opcode_bits"}, 32'(obs8), 32'(op));
        if (ae) begin
            obs24 = '0;
            for (int i = 8; i < 32; i++) obs24 = {obs24[22:0], (i < mosi_q.size()) ? mosi_q[i] : 1'bx};
            check({tag, "_addr_bits"}, 32'(obs24), 32'(ad));
        end
        oe_bad = 0;
        for (int i = 0; i < oe_q.size(); i++) if (oe_q[i] !== (i < n_drive)) oe_bad++;
        check({tag, "_oe_at_rises"}, 32'(oe_bad), 0);
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(len));
        for (int i = 0; i < rx_q.size() && i < 4; i++)
            check($sformatf("%s_rx%0d", tag, i), 32'(rx_q[i]), 32'(slv_mem[i]));
        if (len != 0) check({tag, "_rd_data"}, 32'(rd_data), 32'(slv_mem[len - 1]));
        check({tag, "_done_pulses"}, 32'(done_cnt), 1);
        check({tag, "_cs_low_cycles"}, 32'(cs_low_cyc), 32'((2 * n_rises + 2) * CLK_DIV));
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_idle_cs_n"}, 32'(qspi_cs_n), 1);
        check({tag, "_io0_stable_hi"}, 32'(io0_viol), 0);
        check({tag, "_edges_cs_high"}, 32'(hi_edge_cnt), 0);
    endtask

    initial begin
        int w;
        rst = 1'b1; start = 1'b0; start_d1 = 1'b0; start_d4 = 1'b0;
        opcode = '0; addr = '0; addr_en = 1'b0; rd_len = '0; dummy_cycles = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(qspi_cs_n), 1);
        check("rst_sclk", 32'(qspi_sclk), 0);
        check("rst_io0_o", 32'(qspi_io0_o), 0);
        check("rst_io0_oe", 32'(qspi_io0_oe), 0);
        check("rst_io23_oe", 32'(qspi_io23_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("run_io23_oe", 32'(qspi_io23_oe), 1);
        check("run_io2_io3", 32'({qspi_io2_o, qspi_io3_o}), 32'h3);

        // JEDEC ID with a stray start mid-transfer
        slv_mem[0] = 8'hEF; slv_mem[1] = 8'h40; slv_mem[2] = 8'h18; slv_mem[3] = 8'h00;
        run_txn("jedec", 8'h9F, 24'h0, 1'b0, 8'd3, 4'd0, 1'b1);
        repeat (10) @(negedge clk);
        check("jedec_no_restart", 32'({busy, qspi_cs_n}), 32'h1);

        // Write Enable: command only; rd_data must hold the last byte
        run_txn("wren", 8'h06, 24'h0, 1'b0, 8'd0, 4'd0, 1'b0);
        check("wren_rd_hold", 32'(rd_data), 32'h18);

        // Read with address
        slv_mem[0] = 8'hA5; slv_mem[1] = 8'h5A;
        run_txn("read", 8'h03, 24'h123456, 1'b1, 8'd2, 4'd0, 1'b0);

        // Fast Read with 8 dummy clocks (ignored when the feature is off)
        slv_mem[0] = 8'($urandom);
        run_txn("fastrd", 8'h0B, 24'h0, 1'b1, 8'd1, 4'd8, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4; i++) slv_mem[i] = 8'($urandom);
            run_txn($sformatf("rnd%0d", t), 8'($urandom), 24'($urandom), 1'($urandom),
                    8'($urandom_range(0, 3)), 4'($urandom), 1'b0);
        end

        // Asynchronous reset while the address is going out
        slv_mem[0] = 8'h11; slv_mem[1] = 8'h22;
        slv_hdr = 32; slv_n = 2;
        @(negedge clk);
        opcode = 8'h03; addr = 24'hABCDEF; addr_en = 1'b1; rd_len = 8'd2; dummy_cycles = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(rise_cnt >= 12 && qspi_sclk) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("arst_reached_addr", 32'(qspi_sclk), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_cs_n", 32'(qspi_cs_n), 1);
        check("arst_sclk", 32'(qspi_sclk), 0);
        check("arst_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        check("arst_no_done", 32'(done_cnt), 0);
        check("arst_no_rx", 32'(rx_q.size()), 0);
        check("arst_io23_oe", 32'(qspi_io23_oe), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        slv_mem[0] = 8'hEF; slv_mem[1] = 8'h40; slv_mem[2] = 8'h18;
        run_txn("jedec2", 8'h9F, 24'h0, 1'b0, 8'd3, 4'd0, 1'b0);

        // SCLK period at CLK_DIV=1 and CLK_DIV=4
        opcode = 8'h06; addr = '0; addr_en = 1'b0; rd_len = '0; dummy_cycles = '0;
        start_d1 = 1'b1; start_d4 = 1'b1;
        @(negedge clk);
        start_d1 = 1'b0; start_d4 = 1'b0;
        repeat (150) @(negedge clk);
        check("div1_rises", 32'(x_rise[0]), 8);
        check("div4_rises", 32'(x_rise[1]), 8);
        check("div1_period", 32'(x_second[0] - x_first[0]), 2);
        check("div4_period", 32'(x_second[1] - x_first[1]), 8);
        check("div_cs_idle", 32'(x_cs_n), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
